// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST sequencer.
// Expected truth tables are indexed by {a,b}.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    localparam int unsigned NUM_VECTORS = 4;
    localparam logic [1:0]  LAST_VEC    = 2'd3;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    // Vector applied after the one currently in SAMPLE.
    function automatic logic [1:0] next_vec(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/gate_bist_ctrl_settle_timer.sv
// Settle timer: reloaded on every entry into DRIVE, flags expiry on the
// last of SETTLE_CYCLES enabled cycles.
module bist_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);

    logic [TW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for a single 2-input gate: walks {a,b} through 00..11,
// waits for the gate to settle, compares against a latched truth table.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       expected_tt,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       err_vec
);

    if (CNT_W < 3) begin : g_cnt_w_check
        $error("gate_bist_ctrl: CNT_W must be >= 3");
    end
    if (SETTLE_CYCLES < 1) begin : g_settle_check
        $error("gate_bist_ctrl: SETTLE_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    bist_state_t      r_state;
    bist_state_t      w_state_next;
    logic [1:0]       r_idx;
    logic [3:0]       r_tt;
    logic [1:0]       r_gate_ab;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_err_vec;
    logic             r_pass;

    logic             w_load;
    logic             w_expire;
    logic             w_abort_run;
    logic             w_sample;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_err_next;

    bist_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_en     (r_state == DRIVE),
        .o_expire (w_expire)
    );

    assign w_abort_run = abort && (r_state != IDLE);
    assign w_sample    = (r_state == SAMPLE) && !abort;
    assign w_mismatch  = (gate_y != r_tt[r_idx]);
    assign w_err_next  = (w_sample && w_mismatch && (r_err != ERR_MAX))
                         ? r_err + CNT_W'(1) : r_err;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DRIVE;
                    w_load       = 1'b1;
                end
            end
            DRIVE: begin
                if (w_expire) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (r_idx == LAST_VEC) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRIVE;
                    w_load       = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_abort_run) begin
            w_state_next = IDLE;
            w_load       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort skips the pending compare and keeps the partial tallies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= 2'd0;
            r_tt      <= 4'd0;
            r_gate_ab <= 2'd0;
            r_err     <= '0;
            r_err_vec <= 4'd0;
            r_pass    <= 1'b0;
        end else if (w_abort_run) begin
            r_gate_ab <= 2'd0;
            r_pass    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tt      <= expected_tt;
                        r_idx     <= 2'd0;
                        r_gate_ab <= 2'd0;
                        r_err     <= '0;
                        r_err_vec <= 4'd0;
                        r_pass    <= 1'b0;
                    end
                end
                SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch) begin
                        r_err_vec[r_idx] <= 1'b1;
                    end
                    if (r_idx == LAST_VEC) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx     <= next_vec(r_idx);
                        r_gate_ab <= next_vec(r_idx);
                    end
                end
                DONE: begin
                    r_gate_ab <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign gate_a    = r_gate_ab[1];
    assign gate_b    = r_gate_ab[0];
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE) && !abort;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign err_vec   = r_err_vec;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (SETTLE_CYCLES 2 and 1), each beside
// a truth-table gate model; done-time results are scored against a queue.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]            start_v;
    logic [1:0]            abort_v;
    logic [1:0][3:0]       exp_tt_v;
    logic [1:0][3:0]       gate_tt_v;
    logic [1:0]            gate_a_v;
    logic [1:0]            gate_b_v;
    logic [1:0]            gate_y_v;
    logic [1:0]            busy_v;
    logic [1:0]            done_v;
    logic [1:0]            pass_v;
    logic [1:0][CNT_W-1:0] err_cnt_v;
    logic [1:0][3:0]       err_vec_v;

    assign gate_y_v[0] = gate_tt_v[0][{gate_a_v[0], gate_b_v[0]}];
    assign gate_y_v[1] = gate_tt_v[1][{gate_a_v[1], gate_b_v[1]}];

    gate_bist_ctrl #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) u_dut_s2 (
        .clk(clk), .reset(reset), .start(start_v[0]), .abort(abort_v[0]),
        .expected_tt(exp_tt_v[0]), .gate_a(gate_a_v[0]), .gate_b(gate_b_v[0]),
        .gate_y(gate_y_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_cnt_v[0]), .err_vec(err_vec_v[0])
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(1), .CNT_W(CNT_W)) u_dut_s1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .abort(abort_v[1]),
        .expected_tt(exp_tt_v[1]), .gate_a(gate_a_v[1]), .gate_b(gate_b_v[1]),
        .gate_y(gate_y_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_cnt_v[1]), .err_vec(err_vec_v[1])
    );

    typedef struct packed {
        logic [CNT_W-1:0] err;
        logic [3:0]       vec;
    } sb_t;

    typedef struct packed {
        logic             inst;
        logic [3:0]       gtt;
        logic [3:0]       ett;
        logic [CNT_W-1:0] err;
        logic [3:0]       vec;
        logic             pass;
        logic             disturb;
    } row_t;

    sb_t  sb_q0[$];
    sb_t  sb_q1[$];
    row_t rows[8];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_ab(input int n, input int s);
        int v;
        v = n / (s + 1);
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    always @(negedge clk) begin : mon
        sb_t item;
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (done_v[i] === 1'b1) begin
                    if ((i == 0 && sb_q0.size() == 0) || (i == 1 && sb_q1.size() == 0)) begin
                        check($sformatf("unexpected_done%0d", i), done_v[i], 0);
                    end else begin
                        if (i == 0) item = sb_q0.pop_front();
                        else        item = sb_q1.pop_front();
                        check($sformatf("done_err_count%0d", i), err_cnt_v[i], item.err);
                        check($sformatf("done_err_vec%0d", i), err_vec_v[i], item.vec);
                    end
                end
            end
        end
    end

    task automatic run_case(input int inst, input logic [3:0] gtt, input logic [3:0] ett,
                            input logic [CNT_W-1:0] e_err, input logic [3:0] e_vec,
                            input logic e_pass, input logic disturb, input string tag);
        int  s;
        int  n;
        int  seq_bad;
        sb_t item;
        s = (inst == 0) ? 2 : 1;
        @(negedge clk);
        gate_tt_v[inst] = gtt;
        exp_tt_v[inst]  = ett;
        item.err = e_err;
        item.vec = e_vec;
        if (inst == 0) sb_q0.push_back(item);
        else           sb_q1.push_back(item);
        start_v[inst] = 1'b1;
        @(posedge clk); #1;
        start_v[inst] = 1'b0;
        n = 0;
        seq_bad = 0;
        while (1'b1) begin
            if (busy_v[inst] !== 1'b1) seq_bad++;
            if ({gate_a_v[inst], gate_b_v[inst]} !== exp_ab(n, s)) seq_bad++;
            if (done_v[inst] === 1'b1 || n >= 60) break;
            if (disturb) begin
                if (n == 3) begin
                    start_v[inst]  = 1'b1;
                    exp_tt_v[inst] = ~ett;
                end
                if (n == 6) start_v[inst] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 4 * (s + 1));
        check({tag, "_vec_seq"}, seq_bad, 0);
        if (disturb) start_v[inst] = 1'b1;
        @(posedge clk); #1;
        start_v[inst]  = 1'b0;
        exp_tt_v[inst] = ett;
        check({tag, "_idle_busy"}, busy_v[inst], 0);
        check({tag, "_idle_gate"}, {gate_a_v[inst], gate_b_v[inst]}, 0);
        check({tag, "_pass"}, pass_v[inst], e_pass);
        check({tag, "_err_hold"}, {err_cnt_v[inst], err_vec_v[inst]}, {e_err, e_vec});
    endtask

    initial begin
        start_v   = '0;
        abort_v   = '0;
        gate_tt_v = '0;
        exp_tt_v  = '0;

        rows[0] = '{1'b0, TT_XNOR, TT_XNOR, 3'd0, 4'b0000, 1'b1, 1'b0};
        rows[1] = '{1'b0, 4'b0000, TT_XNOR, 3'd2, 4'b1001, 1'b0, 1'b0};
        rows[2] = '{1'b0, TT_XOR,  TT_XNOR, 3'd4, 4'b1111, 1'b0, 1'b0};
        rows[3] = '{1'b0, TT_AND,  TT_NAND, 3'd4, 4'b1111, 1'b0, 1'b0};
        rows[4] = '{1'b0, TT_OR,   TT_OR,   3'd0, 4'b0000, 1'b1, 1'b1};
        rows[5] = '{1'b0, 4'b1111, TT_NOR,  3'd3, 4'b1110, 1'b0, 1'b0};
        rows[6] = '{1'b1, TT_XNOR, TT_XNOR, 3'd0, 4'b0000, 1'b1, 1'b0};
        rows[7] = '{1'b1, TT_AND,  TT_OR,   3'd2, 4'b0110, 1'b0, 1'b0};

        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_outs%0d", i),
                  {gate_a_v[i], gate_b_v[i], busy_v[i], done_v[i], pass_v[i],
                   err_cnt_v[i], err_vec_v[i]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_case(int'(rows[i].inst), rows[i].gtt, rows[i].ett, rows[i].err,
                     rows[i].vec, rows[i].pass, rows[i].disturb, $sformatf("row%0d", i));
        end

        // Abort in the second SAMPLE with a stuck-at-0 gate.
        @(negedge clk);
        gate_tt_v[0] = 4'b0000;
        exp_tt_v[0]  = TT_XNOR;
        start_v[0]   = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("abort_pre_state", {busy_v[0], gate_a_v[0], gate_b_v[0]}, 3'b101);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check("abort_busy", busy_v[0], 0);
        check("abort_gate", {gate_a_v[0], gate_b_v[0]}, 0);
        check("abort_done_pass", {done_v[0], pass_v[0]}, 0);
        check("abort_partial", {err_cnt_v[0], err_vec_v[0]}, {3'd1, 4'b0001});
        repeat (20) @(posedge clk);
        #1;
        check("abort_stays_idle", busy_v[0], 0);
        run_case(0, TT_XNOR, TT_XNOR, 3'd0, 4'b0000, 1'b1, 1'b0, "post_abort");

        // Asynchronous reset in the middle of a DRIVE phase.
        @(negedge clk);
        gate_tt_v[0] = 4'b0000;
        exp_tt_v[0]  = TT_XNOR;
        start_v[0]   = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_reset_state",
              {busy_v[0], gate_a_v[0], gate_b_v[0], err_cnt_v[0], err_vec_v[0]},
              {1'b1, 2'b01, 3'd1, 4'b0001});
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_mid_run%0d", i),
                  {gate_a_v[i], gate_b_v[i], busy_v[i], done_v[i], pass_v[i],
                   err_cnt_v[i], err_vec_v[i]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        run_case(1, TT_XNOR, TT_XNOR, 3'd0, 4'b0000, 1'b1, 1'b0, "s1_after_reset");
        run_case(0, TT_XOR, TT_XOR, 3'd0, 4'b0000, 1'b1, 1'b0, "s2_after_reset");

        repeat (3) @(posedge clk);
        #1;
        check("sb_left0", sb_q0.size(), 0);
        check("sb_left1", sb_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
